// File: rtl/data_cache.sv
// data_cache -- direct-mapped, write-back, byte-access data cache sitting
// between the CPU datapath and a 256x8 data memory organised as 4-byte blocks.
//
// Ports
//   clock, reset        : system clock (posedge), asynchronous active-high reset
//   read, write         : CPU request; exactly one high means a request
//   address[7:0]        : byte address, tag=[7:5] index=[4:2] offset=[1:0]
//   writedata[7:0]      : CPU write byte
//   readdata[7:0]       : selected byte of the indexed line (combinational)
//   busywait            : CPU stall (combinational)
//   mem_read/mem_write  : block read / block write request to memory
//   mem_address[5:0]    : memory block address
//   mem_writedata[31:0] : block to memory, byte0=[7:0] ... byte3=[31:24]
//   mem_readdata[31:0]  : block from memory, same byte order
//   mem_busywait        : memory busy
//   hit_count/miss_count: saturating statistics counters
//
// Optional feature: define DCACHE_STATS_EN to build the hit/miss counters;
// without it both counter outputs are tied to zero.
module data_cache #(
  parameter int LINES = 8,
  parameter int TAG_W = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic [7:0]  readdata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    MEM_READ   = 2'd2,
    UPDATE     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [5:0]  mem_address_q, mem_address_d;
  logic [31:0] mem_writedata_q, mem_writedata_d;

  logic [TAG_W-1:0] tag_s;
  logic [IDX_W-1:0] idx_s;
  logic [1:0]       off_s;
  logic             req_s;
  logic             hit_s;
  logic [31:0]      line_s;

  assign tag_s  = address[7:8-TAG_W];
  assign idx_s  = address[IDX_W+1:2];
  assign off_s  = address[1:0];
  assign req_s  = read ^ write;
  assign hit_s  = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
  assign line_s = data_q[idx_s];

  // Byte select of the indexed line for the CPU read port.
  always_comb begin
    readdata = line_s[7:0];
    case (off_s)
      2'd0:    readdata = line_s[7:0];
      2'd1:    readdata = line_s[15:8];
      2'd2:    readdata = line_s[23:16];
      2'd3:    readdata = line_s[31:24];
      default: readdata = line_s[7:0];
    endcase
  end

  // Stall while a miss is pending or being serviced; held low during reset
  // because nothing can progress until reset is released.
  assign busywait = !reset && ((req_s && !hit_s) || (state_q != IDLE));

  // Next-state logic and next values of the registered memory-side outputs.
  always_comb begin
    state_d         = state_q;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    mem_address_d   = 6'd0;
    mem_writedata_d = 32'd0;
    case (state_q)
      IDLE: begin
        if (req_s && !hit_s) begin
          if (dirty_q[idx_s]) state_d = WRITE_BACK;
          else                state_d = MEM_READ;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE_BACK: begin
        if (!mem_busywait) state_d = MEM_READ;
        else               state_d = WRITE_BACK;
      end
      MEM_READ: begin
        if (!mem_busywait) state_d = UPDATE;
        else               state_d = MEM_READ;
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Memory outputs are registered, so they are derived from the state being
    // entered; they are then stable for the whole time spent in that state.
    case (state_d)
      WRITE_BACK: begin
        mem_write_d     = 1'b1;
        mem_address_d   = {tag_q[idx_s], idx_s};
        mem_writedata_d = line_s;
      end
      MEM_READ: begin
        mem_read_d    = 1'b1;
        mem_address_d = address[7:2];
      end
      default: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase
  end

  // State, line status bits and memory-side output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      dirty_q         <= '0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= 6'd0;
      mem_writedata_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      if (state_q == UPDATE) begin
        valid_q[idx_s] <= 1'b1;
        dirty_q[idx_s] <= 1'b0;
      end else if (state_q == IDLE && write && !read && hit_s) begin
        dirty_q[idx_s] <= 1'b1;
      end
    end
  end

  // Tag and data arrays; intentionally not cleared by reset.
  always_ff @(posedge clock) begin
    if (state_q == UPDATE) begin
      data_q[idx_s] <= mem_readdata;
      tag_q[idx_s]  <= tag_s;
    end else if (state_q == IDLE && write && !read && hit_s) begin
      data_q[idx_s][{off_s, 3'b000} +: 8] <= writedata;
    end
  end

  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_address   = mem_address_q;
  assign mem_writedata = mem_writedata_q;

`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;
  logic        fill_done_q;

  // Saturating hit/miss counters. fill_done_q marks the IDLE cycle right after
  // a refill so that the completing access of a miss is not counted as a hit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count_q  <= 16'h0000;
      miss_count_q <= 16'h0000;
      fill_done_q  <= 1'b0;
    end else begin
      fill_done_q <= (state_q == UPDATE);
      if (state_q == IDLE && req_s && hit_s && !fill_done_q && hit_count_q != 16'hFFFF)
        hit_count_q <= hit_count_q + 16'h0001;
      else
        hit_count_q <= hit_count_q;
      if (state_q == IDLE && state_d != IDLE && miss_count_q != 16'hFFFF)
        miss_count_q <= miss_count_q + 16'h0001;
      else
        miss_count_q <= miss_count_q;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = 16'h0000;
  assign miss_count = 16'h0000;
`endif

endmodule
